// File: rtl/invader_march_controller_if.sv
// Bus between game_state_machine / alien renderer and the invader march controller.
// The controller connects through the slave modport; its driver uses master.
interface invader_march_controller_if;
    logic       v_sync;
    logic       run;
    logic       reset_game;
    logic [5:0] alive_count;
    logic [7:0] x_offset;
    logic [7:0] y_offset;
    logic       dir;
    logic       step_pulse;
    logic       game_over_trigger;
    logic       wave_clear;

    modport master (
        output v_sync, run, reset_game, alive_count,
        input  x_offset, y_offset, dir, step_pulse, game_over_trigger, wave_clear
    );

    modport slave (
        input  v_sync, run, reset_game, alive_count,
        output x_offset, y_offset, dir, step_pulse, game_over_trigger, wave_clear
    );
endinterface

// File: rtl/invader_march_controller.sv
// Marches the alien formation one step every `period` frames, reverses and descends at the edges,
// speeds up as aliens die, and flags game over at the floor or wave clear when no aliens remain.
module invader_march_controller #(
    parameter int X_MAX       = 64,
    parameter int X_STEP      = 4,
    parameter int Y_STEP      = 8,
    parameter int Y_LIMIT     = 64,
    parameter int MIN_PERIOD  = 2,
    parameter int SPEED_SHIFT = 2
) (
    input logic                        clk,
    input logic                        rst_n,
    invader_march_controller_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, MARCH, DESCEND, OVER, CLEARED} state_t;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic       dir_q, dir_d;
    logic       pulse_q, pulse_d;
    logic       over_q, over_d;
    logic       clear_q, clear_d;
    logic       v_sync_q, v_sync_d;
    logic [6:0] frame_cnt_q, frame_cnt_d;

    logic       tick;
    logic [6:0] period;
    logic [8:0] x_right;
    logic [8:0] y_sum;
    logic [7:0] y_new;

    assign tick    = bus.v_sync & ~v_sync_q;
    assign period  = 7'(MIN_PERIOD) + {1'b0, bus.alive_count >> SPEED_SHIFT};
    assign x_right = {1'b0, x_q} + 9'(X_STEP);
    assign y_sum   = {1'b0, y_q} + 9'(Y_STEP);
    assign y_new   = y_sum[8] ? 8'hFF : y_sum[7:0];

    assign bus.x_offset          = x_q;
    assign bus.y_offset          = y_q;
    assign bus.dir               = dir_q;
    assign bus.step_pulse        = pulse_q;
    assign bus.game_over_trigger = over_q;
    assign bus.wave_clear        = clear_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= 8'd0;
            y_q         <= 8'd0;
            dir_q       <= 1'b0;
            pulse_q     <= 1'b0;
            over_q      <= 1'b0;
            clear_q     <= 1'b0;
            v_sync_q    <= 1'b0;
            frame_cnt_q <= 7'd0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            pulse_q     <= pulse_d;
            over_q      <= over_d;
            clear_q     <= clear_d;
            v_sync_q    <= v_sync_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        pulse_d     = 1'b0;
        v_sync_d    = bus.v_sync;
        frame_cnt_d = frame_cnt_q;

        if (bus.reset_game) begin
            state_d     = IDLE;
            x_d         = 8'd0;
            y_d         = 8'd0;
            dir_d       = 1'b0;
            v_sync_d    = 1'b0;
            frame_cnt_d = 7'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.run) begin
                        state_d     = MARCH;
                        frame_cnt_d = 7'd0;
                    end
                end
                MARCH: begin
                    // An empty formation wins over any step landing on the same edge.
                    if (bus.alive_count == 6'd0) begin
                        state_d = CLEARED;
                    end else if (bus.run && tick) begin
                        if ((frame_cnt_q + 7'd1) >= period) begin
                            frame_cnt_d = 7'd0;
                            if (!dir_q) begin
                                if (x_right > 9'(X_MAX)) begin
                                    state_d = DESCEND;
                                end else begin
                                    x_d     = x_right[7:0];
                                    pulse_d = 1'b1;
                                end
                            end else begin
                                if (x_q < 8'(X_STEP)) begin
                                    state_d = DESCEND;
                                end else begin
                                    x_d     = x_q - 8'(X_STEP);
                                    pulse_d = 1'b1;
                                end
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 7'd1;
                        end
                    end
                end
                DESCEND: begin
                    if (bus.alive_count == 6'd0) begin
                        state_d = CLEARED;
                    end else if (bus.run && tick) begin
                        y_d         = y_new;
                        dir_d       = ~dir_q;
                        pulse_d     = 1'b1;
                        frame_cnt_d = 7'd0;
                        state_d     = (y_new >= 8'(Y_LIMIT)) ? OVER : MARCH;
                    end
                end
                OVER: begin
                end
                CLEARED: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        over_d  = (state_d == OVER);
        clear_d = (state_d == CLEARED);
    end
endmodule

// File: tb/tb_invader_march_controller.sv
// Self-checking bench for invader_march_controller: a vector table plus hand-written sequences,
// with every expected output queued on a scoreboard when its stimulus is driven.
module tb_invader_march_controller;
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       dir;
        logic       pulse;
        logic       over;
        logic       clear;
    } exp_t;

    typedef struct packed {
        logic       rst_n;
        logic       reset_game;
        logic       run;
        logic [5:0] alive;
        logic       tick;
        exp_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    invader_march_controller_if bus();

    invader_march_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input logic [7:0] x, input logic [7:0] y, input logic dir,
                                    input logic pulse, input logic over, input logic clear);
        exp_t e;
        e.x = x; e.y = y; e.dir = dir; e.pulse = pulse; e.over = over; e.clear = clear;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic r, input logic rg, input logic rn,
                                    input logic [5:0] alive, input logic tick, input exp_t e);
        vec_t v;
        v.rst_n = r; v.reset_game = rg; v.run = rn; v.alive = alive; v.tick = tick; v.exp = e;
        return v;
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        exp_t a;
        e = sb_q.pop_front();
        a = {bus.x_offset, bus.y_offset, bus.dir, bus.step_pulse, bus.game_over_trigger, bus.wave_clear};
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("[TB] FAIL %s: got x=%0d y=%0d dir=%b pulse=%b over=%b clear=%b, expected x=%0d y=%0d dir=%b pulse=%b over=%b clear=%b",
                     name, a.x, a.y, a.dir, a.pulse, a.over, a.clear,
                     e.x, e.y, e.dir, e.pulse, e.over, e.clear);
        end
    endtask

    // A tick vector spends two clocks: the v_sync rising edge, then the release where the pulse must be gone.
    task automatic applyStimulus(input vec_t v, input string name);
        exp_t rel;
        rst_n           = v.rst_n;
        bus.reset_game  = v.reset_game;
        bus.run         = v.run;
        bus.alive_count = v.alive;
        bus.v_sync      = v.tick;
        sb_q.push_back(v.exp);
        step_clk();
        checkOutput(name);
        if (v.tick) begin
            bus.v_sync = 1'b0;
            rel        = v.exp;
            rel.pulse  = 1'b0;
            sb_q.push_back(rel);
            step_clk();
            checkOutput({name, " release"});
        end
    endtask

    task automatic tick_row(input string name, input logic rn, input logic [5:0] alive, input exp_t e);
        applyStimulus(mk_vec(1'b1, 1'b0, rn, alive, 1'b1, e), name);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t zero;
        zero            = mk_exp(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n           = 1'b0;
        bus.v_sync      = 1'b0;
        bus.run         = 1'b0;
        bus.reset_game  = 1'b0;
        bus.alive_count = 6'd40;

        vecs.push_back(mk_vec(1'b0, 1'b0, 1'b0, 6'd40, 1'b1, zero));
        vecs.push_back(mk_vec(1'b0, 1'b1, 1'b1, 6'd40, 1'b1, zero));
        vecs.push_back(mk_vec(1'b1, 1'b1, 1'b1, 6'd40, 1'b1, zero));
        vecs.push_back(mk_vec(1'b1, 1'b1, 1'b1, 6'd40, 1'b1, zero));
        vecs.push_back(mk_vec(1'b1, 1'b0, 1'b1, 6'd40, 1'b0, zero));
        for (int s = 1; s <= 16; s++) begin
            for (int f = 1; f <= 12; f++) begin
                vecs.push_back(mk_vec(1'b1, 1'b0, 1'b1, 6'd40, 1'b1,
                    mk_exp(8'((f == 12) ? 4 * s : 4 * (s - 1)), 8'd0, 1'b0, (f == 12), 1'b0, 1'b0)));
            end
        end
        for (int f = 1; f <= 12; f++) begin
            vecs.push_back(mk_vec(1'b1, 1'b0, 1'b1, 6'd40, 1'b1, mk_exp(8'd64, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
        end
        vecs.push_back(mk_vec(1'b1, 1'b0, 1'b1, 6'd40, 1'b1, mk_exp(8'd64, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0)));
        for (int f = 1; f <= 12; f++) begin
            vecs.push_back(mk_vec(1'b1, 1'b0, 1'b1, 6'd40, 1'b1,
                mk_exp(8'((f == 12) ? 60 : 64), 8'd8, 1'b1, (f == 12), 1'b0, 1'b0)));
        end

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec[%0d]", i));

        // Pause in MARCH: the count held at 8 needs only 4 more ticks once run returns.
        for (int f = 0; f < 8; f++)  tick_row("pre-pause", 1'b1, 6'd40, mk_exp(8'd60, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int f = 0; f < 20; f++) tick_row("paused", 1'b0, 6'd40, mk_exp(8'd60, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int f = 0; f < 3; f++)  tick_row("resumed", 1'b1, 6'd40, mk_exp(8'd60, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0));
        tick_row("resume step", 1'b1, 6'd40, mk_exp(8'd56, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0));

        // Period shrinks from 12 to 2 with the count at 8, then the last alien dies on a step tick.
        for (int f = 0; f < 8; f++) tick_row("count to 8", 1'b1, 6'd40, mk_exp(8'd56, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0));
        tick_row("speedup step", 1'b1, 6'd3, mk_exp(8'd52, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0));
        tick_row("fast count", 1'b1, 6'd3, mk_exp(8'd52, 8'd8, 1'b1, 1'b0, 1'b0, 1'b0));
        tick_row("clear on step", 1'b1, 6'd0, mk_exp(8'd52, 8'd8, 1'b1, 1'b0, 1'b0, 1'b1));
        for (int f = 0; f < 3; f++) tick_row("cleared frozen", 1'b1, 6'd0, mk_exp(8'd52, 8'd8, 1'b1, 1'b0, 1'b0, 1'b1));
        applyStimulus(mk_vec(1'b1, 1'b1, 1'b1, 6'd0, 1'b0, zero), "reset_game from cleared");
        applyStimulus(mk_vec(1'b1, 1'b0, 1'b0, 6'd3, 1'b0, zero), "idle after reset_game");

        // Reach DESCEND quickly, then reset_game on the tick that would have committed the descent.
        applyStimulus(mk_vec(1'b1, 1'b0, 1'b1, 6'd3, 1'b0, zero), "start fast march");
        for (int k = 1; k <= 32; k++) begin
            tick_row("fast march", 1'b1, 6'd3,
                mk_exp(8'((k % 2 == 0) ? 2 * k : 2 * (k - 1)), 8'd0, 1'b0, (k % 2 == 0), 1'b0, 1'b0));
        end
        for (int k = 0; k < 2; k++) tick_row("fast edge", 1'b1, 6'd3, mk_exp(8'd64, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        applyStimulus(mk_vec(1'b1, 1'b1, 1'b1, 6'd3, 1'b1, zero), "reset_game in descend");
        applyStimulus(mk_vec(1'b1, 1'b0, 1'b0, 6'd3, 1'b0, zero), "idle hold");
        tick_row("idle ignores tick", 1'b0, 6'd3, zero);

        // Full game with period 17: eight sweeps and descents, the eighth landing on the floor.
        applyStimulus(mk_vec(1'b1, 1'b0, 1'b1, 6'd63, 1'b0, zero), "start slow march");
        for (int d = 0; d < 8; d++) begin
            for (int s = 1; s <= 16; s++) begin
                for (int f = 1; f <= 17; f++) begin
                    int moved;
                    moved = (f == 17) ? s : s - 1;
                    tick_row($sformatf("sweep %0d step %0d", d, s), 1'b1, 6'd63,
                        mk_exp(8'((d % 2 == 0) ? 4 * moved : 64 - 4 * moved), 8'(8 * d), 1'(d % 2),
                               (f == 17), 1'b0, 1'b0));
                end
            end
            for (int f = 1; f <= 17; f++) begin
                tick_row($sformatf("sweep %0d edge", d), 1'b1, 6'd63,
                    mk_exp(8'((d % 2 == 0) ? 64 : 0), 8'(8 * d), 1'(d % 2), 1'b0, 1'b0, 1'b0));
            end
            tick_row($sformatf("descent %0d", d + 1), 1'b1, 6'd63,
                mk_exp(8'((d % 2 == 0) ? 64 : 0), 8'(8 * (d + 1)), 1'((d + 1) % 2), 1'b1, (d == 7), 1'b0));
        end
        for (int f = 0; f < 3; f++) tick_row("over frozen", 1'b1, 6'd63, mk_exp(8'd0, 8'd64, 1'b0, 1'b0, 1'b1, 1'b0));
        applyStimulus(mk_vec(1'b1, 1'b1, 1'b1, 6'd63, 1'b0, zero), "reset_game from over");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
